dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Shares the single data-memory port (dmem) between the processor's load/store path (CPU) and an external loader/debug master (EXT).
- Sits between the core's ALU address / rs2 write-data / dmem_ctrl signals and the dmem instance.
- Grants one access per clock and produces a stall for the core's PC and register write-enable when the CPU loses arbitration.
- CPU has priority by default, with a bounded-starvation guarantee for EXT.

Parameters:
- MAX_HOLD, 4: maximum consecutive contended CPU grants before EXT is owed a grant (legal range 1-15).
- CNT_W, 16: width of the performance counters (optional feature only).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU memory access request (load or store this cycle).
- cpu_we  in  1  CPU store (1) or load (0).
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU store data.
- cpu_ctrl  in  3  CPU access size/sign code, dmem_ctrl encoding.
- cpu_gnt  out  1  CPU access performed this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt; core must hold PC and suppress register write.
- ext_req, ext_we, ext_addr[31:0], ext_wdata[31:0], ext_ctrl[2:0]  in  -  EXT equivalents.
- ext_gnt  out  1  EXT access performed this cycle.
- rdata  out  32  mem_rdata forwarded; valid for whichever requester has gnt with we=0.
- mem_addr  out  32  to dmem addr.
- mem_wdata  out  32  to dmem w_data.
- mem_ctrl  out  3  to dmem ctrl.
- mem_w_en  out  1  to dmem w_en.
- mem_rdata  in  32  from dmem outdata (combinational read).

Behaviour:
- Grant is combinational in the request cycle; the access completes at that rising edge. dmem writes on CLK and reads combinationally, so the latency is 0 cycles.
- At most one of cpu_gnt/ext_gnt is high. gnt_x is never high without req_x.
- Requesters hold req and all attribute signals stable while not granted. A req seen with gnt high is consumed. A req still high in the next cycle is a new access.
- Mux: mem_* come from the granted requester. With no grant, mem_w_en=0, mem_addr/wdata/ctrl=0.
- FSM state CPU_PRI (reset state):
  - Only one requester: that requester is granted.
  - Both requesting: CPU is granted and hold_cnt increments. When hold_cnt reaches MAX_HOLD, go to EXT_OWED.
  - ext_req=0: hold_cnt clears to 0.
- FSM state EXT_OWED:
  - ext_req=1: EXT is granted, even if cpu_req=1. hold_cnt clears to 0; return to CPU_PRI.
  - ext_req=0 (EXT withdrew): CPU granted if requesting; hold_cnt clears; return to CPU_PRI.
- hold_cnt is 4 bits and saturates at MAX_HOLD; it never wraps.
- The EXT grant path does not use hold_cnt. Uncontested EXT streams are granted every cycle.
- Reset (RST=0, asynchronous):
  - state=CPU_PRI, hold_cnt=0.
  - cpu_gnt, ext_gnt, mem_w_en and cpu_stall forced 0 while RST=0.
- Reset mid-contention discards any owed EXT turn. The first cycle after release behaves as CPU_PRI with hold_cnt=0.
- Same-address simultaneous write/read from both masters: only the granted access occurs. The loser retries next cycle and sees the updated data.

Optional Feature:
DMEM_ARB_PERF_EN

Defined:
- Adds outputs perf_cpu_stall[CNT_W-1:0] (counts cycles with cpu_stall=1).
- Adds perf_ext_grant[CNT_W-1:0] (counts cycles with ext_gnt=1).
- Adds input perf_clr (synchronous clear to 0, priority over increment).
- Both counters saturate at all-ones and reset to 0 on RST=0.

Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- CPU only: cpu_req=1, cpu_we=1, addr=0x10, wdata=0xDEADBEEF, ctrl=word; then a load from 0x10 -> cpu_gnt=1 both cycles, mem_w_en=1 then 0, rdata=0xDEADBEEF on the load, cpu_stall=0.
- EXT only: ext writes 0x1,0x2,0x3 to 0x0,0x4,0x8 on consecutive cycles -> ext_gnt=1 each cycle, no gaps, memory holds the values.
- Contention, MAX_HOLD=4, both req held high for 10 cycles -> grant pattern C,C,C,C,E,C,C,C,C,E. cpu_stall=1 exactly in the E cycles.
- EXT withdraws while owed: 4 contended cycles, then ext_req=0 -> next cycle cpu_gnt=1, state back to CPU_PRI. Re-contention needs 4 more CPU grants before EXT wins.
- Async reset: assert RST=0 mid-cycle during EXT_OWED -> gnts and mem_w_en drop immediately. After release with both requesting, CPU wins the first 4 cycles.
- With DMEM_ARB_PERF_EN, run the contention scenario -> perf_cpu_stall=2, perf_ext_grant=2. perf_clr pulse -> both 0 next cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the core's
// load/store path (CPU) and an external loader/debug master (EXT).
// The CPU wins by default. After MAX_HOLD consecutive contended CPU grants,
// EXT is owed the next grant. Grants are combinational with 0-cycle latency:
// the granted access completes at the rising edge that ends the request cycle.
// Optional build macro DMEM_ARB_PERF_EN adds saturating stall/grant counters.
module dmem_arbiter #(
    parameter int MAX_HOLD = 4
`ifdef DMEM_ARB_PERF_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_ctrl,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [2:0]  ext_ctrl,
    output logic        ext_gnt,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_ctrl,
    output logic        mem_w_en,
    input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] perf_cpu_stall,
    output logic [CNT_W-1:0] perf_ext_grant
`endif
);

    typedef enum logic {
        CPU_PRI  = 1'b0,
        EXT_OWED = 1'b1
    } state_e;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_e     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic       cpu_win, ext_win;

    // State register and contended-grant counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= CPU_PRI;
            hold_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments for all flops so every register
            // samples pre-edge values regardless of statement order.
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state and grant decision.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_d = state_q;
        hold_d  = hold_q;
        cpu_win = 1'b0;
        ext_win = 1'b0;
        case (state_q)
            CPU_PRI: begin
                if (cpu_req && ext_req) begin
                    cpu_win = 1'b1;
                    if (hold_q >= HOLD_MAX - 4'd1) begin
                        hold_d  = HOLD_MAX;
                        state_d = EXT_OWED;
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end else begin
                    // Uncontested: serve whoever asks; contention streak ends.
                    cpu_win = cpu_req;
                    ext_win = ext_req;
                    hold_d  = '0;
                end
            end
            EXT_OWED: begin
                // Pay the owed turn if EXT is still asking, else fall back to CPU.
                ext_win = ext_req;
                cpu_win = cpu_req & ~ext_req;
                hold_d  = '0;
                state_d = CPU_PRI;
            end
            default: begin
                state_d = CPU_PRI;
                hold_d  = '0;
            end
        endcase
    end

    // Grants and stall are forced low while reset is asserted, without waiting for a clock.
    assign cpu_gnt   = RST & cpu_win;
    assign ext_gnt   = RST & ext_win;
    assign cpu_stall = RST & cpu_req & ~cpu_win;
    assign rdata     = mem_rdata;

    // Memory-port mux: the granted requester drives dmem, idle drives zeros.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_ctrl  = '0;
        mem_w_en  = 1'b0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_ctrl  = cpu_ctrl;
            mem_w_en  = cpu_we;
        end else if (ext_gnt) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_ctrl  = ext_ctrl;
            mem_w_en  = ext_we;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, egnt_cnt_q;

    // Saturating performance counters; clear has priority over counting.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_cnt_q <= '0;
            egnt_cnt_q  <= '0;
        end else if (perf_clr) begin
            stall_cnt_q <= '0;
            egnt_cnt_q  <= '0;
        end else begin
            if (cpu_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (ext_gnt && (egnt_cnt_q != '1))    egnt_cnt_q  <= egnt_cnt_q + 1'b1;
        end
    end

    assign perf_cpu_stall = stall_cnt_q;
    assign perf_ext_grant = egnt_cnt_q;
`endif

endmodule
